sd_loader_mem_sequencer: RTL and testbench
==========================================

# sd_loader_mem_sequencer

Avalon-MM slave in the Nios SD-loader system that moves bytes written by the Nios CPU into the ZX Spectrum memory bus. It replaces hand-toggled PIO address and strobe writes with a self-sequencing engine. Firmware programs a base address and a byte count, then streams bytes into a small FIFO. The block requests the memory bus, issues timed write cycles with an auto-incrementing address, and releases the bus when the count is exhausted.

## Interface
- WR_CYCLES, 2: cycles `mem_we_n` (and `mem_oe_n` in verify) is held low; legal range 1..15.
- FIFO_DEPTH, 4: byte FIFO depth; power of two, 2..16.
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  3  Avalon register select.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, combinational from address, unused bits 0.
- mem_req  out  1  bus request to the Spectrum side.
- mem_gnt  in  1  bus grant, synchronous to clk.
- mem_addr  out  16  memory address.
- mem_wdata  out  8  memory write data.
- mem_we_n  out  1  write strobe, active-low.
- mem_oe_n  out  1  read strobe, active-low.
- mem_rdata  in  8  memory read data (verify only).

## Operation
- Register 0 BASE: RW, bits 15:0. Register 1 COUNT: RW, bits 15:0; 0 means no transfer. Register 2 DATA: a write pushes `writedata[7:0]` into the FIFO. Register 3 CTRL/STATUS:
  - Write bit0 = start, bit1 = abort.
  - Read bit0 busy, bit1 fifo_full, bit2 done (sticky), bit3 overflow (sticky), bit4 verify_err (sticky), bits 12:8 fifo level.
- Register 4 CUR_ADDR: RO, 16 bits. Other addresses read 0.
- A start write clears the sticky bits, loads cur_addr from BASE and remaining from COUNT.
- States:
  - IDLE -> REQ on start with COUNT≠0.
  - IDLE with COUNT=0: done=1, no request.
  - REQ: `mem_req`=1; waits for `mem_gnt` and FIFO not empty, then -> SETUP.
  - SETUP: 1 cycle, addr and data driven, strobes high; pops the FIFO.
  - STROBE: WR_CYCLES cycles with `mem_we_n`=0.
  - HOLD: 1 cycle, strobes high, addr and data stable. Then cur_addr+1 mod 2^16 and remaining−1.
  - HOLD exit: remaining=0 -> RELEASE; otherwise -> REQ.
  - RELEASE: `mem_req`=0, done=1 -> IDLE.
- Grant drops while in REQ: stay in REQ. Grant drops during SETUP, STROBE or HOLD: the cycle completes regardless.
- Start while busy: ignored.
- Abort: from REQ, go to RELEASE at once with done=0. Mid-cycle, finish through HOLD, then RELEASE. After an abort the FIFO is flushed.
- DATA write with the FIFO full: byte dropped, overflow=1. A DATA write in the same cycle as a SETUP pop is accepted even when full.
- Address wraps 0xFFFF -> 0x0000 silently.

## Timing
- Reset values: `mem_req`=0, `mem_we_n`=1, `mem_oe_n`=1, `mem_addr`=0, `mem_wdata`=0. All registers 0, FIFO empty, state IDLE.
- Reset asserted mid-cycle forces these values immediately.
- All memory outputs are registered.
- Start to `mem_req`=1: 1 cycle.
- Grant with data available to `mem_we_n` low: 2 cycles (REQ sample, SETUP).
- Per byte with grant held and FIFO non-empty: WR_CYCLES+3 cycles (REQ, SETUP, STROBE, HOLD).
- `mem_req` stays 1 between back-to-back bytes.

## Configuration
- SD_LOADER_VERIFY_EN defined: a VERIFY state is inserted after HOLD.
  - VERIFY holds `mem_oe_n`=0 for WR_CYCLES cycles.
  - `mem_rdata` is compared against the written byte on the last VERIFY cycle.
  - Mismatch: verify_err=1, go to RELEASE with done=0.
  - Per-byte cost rises to 2·WR_CYCLES+3.
- SD_LOADER_VERIFY_EN undefined: no VERIFY state, `mem_oe_n` tied 1, status bit4 reads 0.

## Structure
- Package `sd_loader_pkg`: state enum, register offset constants, status bit indices.
- Sub-module `sd_loader_byte_fifo`: FIFO_DEPTH×8 synchronous FIFO with full, empty and level outputs.

## Test plan
- BASE=0x4000, COUNT=3, push 0x11/0x22/0x33, start, grant held -> writes at 0x4000..0x4002 with matching data, each `mem_we_n` low exactly 2 cycles, then done=1 and `mem_req`=0.
- BASE=0xFFFF, COUNT=2 -> writes at 0xFFFF then 0x0000; CUR_ADDR reads 0x0001.
- Push 5 bytes with FIFO_DEPTH=4 -> level=4, overflow=1, the 5th byte is never written.
- Grant withheld 10 cycles after start -> no strobe; `mem_we_n` falls exactly 2 cycles after the grant rises.
- Abort during STROBE -> the strobe completes its full width, `mem_req` falls, done=0, FIFO level=0.
- With SD_LOADER_VERIFY_EN, write 0xA5 with the memory model returning 0xA4 -> verify_err=1, transfer stops after that byte.

Source files
------------

// File: rtl/sd_loader_pkg.sv
// Shared types and constants for the SD-loader memory sequencer.
package sd_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_VERIFY,
    S_RELEASE
  } seq_state_e;

  localparam logic [2:0] REG_BASE     = 3'd0;
  localparam logic [2:0] REG_COUNT    = 3'd1;
  localparam logic [2:0] REG_DATA     = 3'd2;
  localparam logic [2:0] REG_CTRL     = 3'd3;
  localparam logic [2:0] REG_CUR_ADDR = 3'd4;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_DONE   = 2;
  localparam int STAT_OVF    = 3;
  localparam int STAT_VERR   = 4;
  localparam int STAT_LVL_LO = 8;

endpackage

// File: rtl/sd_loader_byte_fifo.sv
// DEPTH x 8 synchronous FIFO; push while full is accepted only if a pop happens the same cycle.
module sd_loader_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && (level_q != '0) && !flush;
    push_ok  = push && !flush && ((level_q != FULL_LVL) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (level_q == FULL_LVL);
  assign empty    = (level_q == '0);
  assign level    = level_q;

endmodule

// File: rtl/sd_loader_mem_sequencer.sv
// Avalon-MM slave that streams FIFO'd bytes into Spectrum memory with timed write cycles.
// Define SD_LOADER_VERIFY_EN to add a read-back VERIFY phase after every write.
module sd_loader_mem_sequencer
  import sd_loader_pkg::*;
#(
  parameter int WR_CYCLES  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we_n,
  output logic        mem_oe_n,
  input  logic [7:0]  mem_rdata
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  seq_state_e  state_q, state_d;
  logic [15:0] base_q, base_d, count_q, count_d;
  logic [15:0] cur_addr_q, cur_addr_d, remaining_q, remaining_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d, ovf_q, ovf_d, verr_q, verr_d;
  logic        fail_q, fail_d, abort_pend_q, abort_pend_d;
  logic        mem_req_q, mem_req_d, mem_we_n_q, mem_we_n_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;

  logic          av_wr, start, abort, push, pop, flush, abort_now;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [LW-1:0] fifo_level;
  logic          unused_wdata;

  assign av_wr        = chipselect && !write_n;
  assign start        = av_wr && (address == REG_CTRL) && writedata[CTRL_START];
  assign abort        = av_wr && (address == REG_CTRL) && writedata[CTRL_ABORT];
  assign push         = av_wr && (address == REG_DATA);
  assign unused_wdata = ^writedata[31:16];

  sd_loader_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (push),
    .push_data (writedata[7:0]),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    count_d      = count_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    cnt_d        = cnt_q;
    done_d       = done_q;
    ovf_d        = ovf_q;
    verr_d       = verr_q;
    fail_d       = fail_q;
    abort_pend_d = abort_pend_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    pop          = 1'b0;
    flush        = 1'b0;
    abort_now    = abort || abort_pend_q;

    if (av_wr && address == REG_BASE)  base_d  = writedata[15:0];
    if (av_wr && address == REG_COUNT) count_d = writedata[15:0];

    case (state_q)
      S_IDLE: begin
        if (abort) flush = 1'b1;
        else if (start) begin
          done_d       = 1'b0;
          ovf_d        = 1'b0;
          verr_d       = 1'b0;
          fail_d       = 1'b0;
          abort_pend_d = 1'b0;
          cur_addr_d   = base_q;
          remaining_d  = count_q;
          if (count_q == 16'd0) done_d = 1'b1;
          else                  state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (abort_now) begin
          state_d      = S_RELEASE;
          fail_d       = 1'b1;
          abort_pend_d = 1'b1;
        end else if (mem_gnt && !fifo_empty) begin
          state_d     = S_SETUP;
          pop         = 1'b1;
          mem_addr_d  = cur_addr_q;
          mem_wdata_d = fifo_rdata;
        end
      end
      S_SETUP: begin
        if (abort) abort_pend_d = 1'b1;
        state_d = S_STROBE;
        cnt_d   = 4'(WR_CYCLES - 1);
      end
      S_STROBE: begin
        if (abort) abort_pend_d = 1'b1;
        if (cnt_q == 4'd0) state_d = S_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_HOLD: begin
        cur_addr_d  = cur_addr_q + 16'd1;
        remaining_d = remaining_q - 16'd1;
`ifdef SD_LOADER_VERIFY_EN
        if (abort) abort_pend_d = 1'b1;
        state_d = S_VERIFY;
        cnt_d   = 4'(WR_CYCLES - 1);
`else
        if (abort_now) begin
          state_d      = S_RELEASE;
          fail_d       = 1'b1;
          abort_pend_d = 1'b1;
        end else if (remaining_q == 16'd1) state_d = S_RELEASE;
        else                               state_d = S_REQ;
`endif
      end
`ifdef SD_LOADER_VERIFY_EN
      S_VERIFY: begin
        if (abort) abort_pend_d = 1'b1;
        // Read data is judged only on the final cycle of the OE window.
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else if (mem_rdata != mem_wdata_q) begin
          verr_d  = 1'b1;
          fail_d  = 1'b1;
          state_d = S_RELEASE;
        end else if (abort_now) begin
          fail_d       = 1'b1;
          abort_pend_d = 1'b1;
          state_d      = S_RELEASE;
        end else if (remaining_q == 16'd0) state_d = S_RELEASE;
        else                               state_d = S_REQ;
      end
`endif
      S_RELEASE: begin
        done_d  = !fail_q;
        flush   = abort_pend_q || abort;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (push && fifo_full && !pop) ovf_d = 1'b1;

    // Bus outputs are registered from the next state so they line up with it.
    mem_req_d  = state_d inside {S_REQ, S_SETUP, S_STROBE, S_HOLD, S_VERIFY};
    mem_we_n_d = (state_d != S_STROBE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      count_q      <= '0;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      verr_q       <= 1'b0;
      fail_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_n_q   <= 1'b1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      count_q      <= count_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      verr_q       <= verr_d;
      fail_q       <= fail_d;
      abort_pend_q <= abort_pend_d;
      mem_req_q    <= mem_req_d;
      mem_we_n_q   <= mem_we_n_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

`ifdef SD_LOADER_VERIFY_EN
  logic mem_oe_n_q, mem_oe_n_d;
  assign mem_oe_n_d = (state_d != S_VERIFY);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_oe_n_q <= 1'b1;
    else          mem_oe_n_q <= mem_oe_n_d;
  end
  assign mem_oe_n = mem_oe_n_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign mem_oe_n     = 1'b1;
`endif

  assign mem_req   = mem_req_q;
  assign mem_we_n  = mem_we_n_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    readdata = '0;
    case (address)
      REG_BASE:     readdata[15:0] = base_q;
      REG_COUNT:    readdata[15:0] = count_q;
      REG_CTRL: begin
        readdata[STAT_BUSY]          = (state_q != S_IDLE);
        readdata[STAT_FULL]          = fifo_full;
        readdata[STAT_DONE]          = done_q;
        readdata[STAT_OVF]           = ovf_q;
        readdata[STAT_VERR]          = verr_q;
        readdata[STAT_LVL_LO +: 5]   = 5'(fifo_level);
      end
      REG_CUR_ADDR: readdata[15:0] = cur_addr_q;
      default:      readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_sd_loader_mem_sequencer.sv
// Self-checking bench: directed scenarios plus randomized transfers against a queue-based model.
module tb_sd_loader_mem_sequencer;
  localparam int W = 2;
  localparam int D = 4;
`ifdef SD_LOADER_VERIFY_EN
  localparam int PER_BYTE = 2*W + 3;
`else
  localparam int PER_BYTE = W + 3;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we_n;
  logic        mem_oe_n;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem_model [65536];
  logic [7:0]  rd_corrupt = 8'h00;
  assign mem_rdata = mem_model[mem_addr] ^ rd_corrupt;

  sd_loader_mem_sequencer #(.WR_CYCLES(W), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we_n   (mem_we_n),
    .mem_oe_n   (mem_oe_n),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write-strobe monitor: one record per WE low pulse.
  int          cyc = 0;
  int          we_run = 0;
  int          mon_addr[$], mon_data[$], mon_width[$], mon_fall[$];
  logic [15:0] cap_addr;
  logic [7:0]  cap_data;

  always @(negedge clk) begin
    cyc++;
    if (!mem_we_n) begin
      if (we_run == 0) begin
        cap_addr = mem_addr;
        cap_data = mem_wdata;
        mon_fall.push_back(cyc);
      end
      mem_model[mem_addr] = mem_wdata;
      we_run++;
    end else if (we_run != 0) begin
      mon_addr.push_back(int'(cap_addr));
      mon_data.push_back(int'(cap_data));
      mon_width.push_back(we_run);
      we_run = 0;
    end
  end

  task automatic mon_clear();
    mon_addr.delete(); mon_data.delete(); mon_width.delete(); mon_fall.delete();
  endtask

  task automatic av_wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic av_rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // Model: FIFO contents as a queue, overflow sticky since last start.
  logic [7:0] mfifo[$];
  bit         movf = 1'b0;

  task automatic push_byte(input logic [7:0] b);
    logic [31:0] junk;
    junk = $urandom;
    av_wr(3'd2, {junk[31:8], b});
    if (mfifo.size() < D) mfifo.push_back(b);
    else                  movf = 1'b1;
  endtask

  task automatic start_xfer();
    av_wr(3'd3, 32'h1);
    movf = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd_gnt);
    logic [31:0] st;
    int n = 0;
    av_rd(3'd3, st);
    while (st[0] && n < 3000) begin
      @(posedge clk); #1;
      if (rnd_gnt) mem_gnt = ($urandom_range(0, 3) != 0);
      n++;
      av_rd(3'd3, st);
    end
    chk("idle_reached", 32'(st[0]), 32'd0);
  endtask

  task automatic wait_we_low(input string tag);
    int n = 0;
    while (mem_we_n && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(mem_we_n), 32'd0);
  endtask

  task automatic run_xfer(input logic [15:0] base, input logic [15:0] cnt, input bit rnd);
    logic [31:0] st, ca;
    logic [7:0]  exp_b[$];
    logic [15:0] ea;
    for (int i = 0; i < int'(cnt); i++) exp_b.push_back(mfifo.pop_front());
    av_wr(3'd0, {16'hdead, base});
    av_wr(3'd1, {16'hbeef, cnt});
    mon_clear();
    start_xfer();
    wait_idle(rnd);
    chk("n_writes", 32'(mon_addr.size()), 32'(cnt));
    for (int i = 0; i < mon_addr.size() && i < int'(cnt); i++) begin
      ea = base + 16'(i);
      chk("wr_addr", 32'(mon_addr[i]), {16'h0, ea});
      chk("wr_data", 32'(mon_data[i]), {24'h0, exp_b[i]});
      chk("we_width", 32'(mon_width[i]), 32'(W));
    end
    av_rd(3'd3, st);
    chk("done", 32'(st[2]), 32'd1);
    chk("ovf_clr", 32'(st[3]), 32'd0);
    chk("verr", 32'(st[4]), 32'd0);
    chk("level", 32'(st[12:8]), 32'(mfifo.size()));
    ea = base + cnt;
    av_rd(3'd4, ca);
    chk("cur_addr", ca, {16'h0, ea});
    chk("req_off", 32'(mem_req), 32'd0);
    chk("we_idle", 32'(mem_we_n), 32'd1);
    chk("oe_idle", 32'(mem_oe_n), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int          n;
    int          np;
    logic [15:0] base;
    logic [15:0] cnt;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we_n), 32'd1);
    chk("rst_oe", 32'(mem_oe_n), 32'd1);
    chk("rst_addr", {16'h0, mem_addr}, 32'd0);
    chk("rst_wdata", {24'h0, mem_wdata}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 8; a++) begin
      av_rd(3'(a), rd);
      chk("rst_reg", rd, 32'd0);
    end

    // Basic 3-byte transfer with grant held
    mem_gnt = 1'b1;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    run_xfer(16'h4000, 16'd3, 1'b0);
    if (mon_fall.size() == 3) begin
      chk("spacing0", 32'(mon_fall[1] - mon_fall[0]), 32'(PER_BYTE));
      chk("spacing1", 32'(mon_fall[2] - mon_fall[1]), 32'(PER_BYTE));
    end else chk("fall_cnt", 32'(mon_fall.size()), 32'd3);
    av_rd(3'd0, rd); chk("base_rb", rd, 32'h4000);
    av_rd(3'd1, rd); chk("count_rb", rd, 32'd3);
    av_rd(3'd5, rd); chk("reg5_zero", rd, 32'd0);

    // Address wrap
    push_byte(8'hc3); push_byte(8'h3c);
    run_xfer(16'hffff, 16'd2, 1'b0);

    // Overflow: fifth byte dropped
    for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i));
    av_rd(3'd3, rd);
    chk("ovf_level", 32'(rd[12:8]), 32'd4);
    chk("ovf_full", 32'(rd[1]), 32'd1);
    chk("ovf_flag", 32'(rd[3]), 32'(movf));
    run_xfer(16'h1230, 16'd4, 1'b0);

    // Zero count: done without a request
    run_xfer(16'h0abc, 16'd0, 1'b0);

    // Grant withheld
    mem_gnt = 1'b0;
    push_byte(8'h77);
    av_wr(3'd0, 32'h2345); av_wr(3'd1, 32'd1);
    mon_clear();
    chk("req_pre", 32'(mem_req), 32'd0);
    start_xfer();
    chk("req_1cyc", 32'(mem_req), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("no_strobe", 32'(mon_fall.size()), 32'd0);
    chk("we_high", 32'(mem_we_n), 32'd1);
    mem_gnt = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (mem_we_n && n < 20);
    chk("gnt_to_we", 32'(n), 32'd2);
    wait_idle(1'b0);
    void'(mfifo.pop_front());
    chk("gw_writes", 32'(mon_addr.size()), 32'd1);

    // Start while busy is ignored
    mem_gnt = 1'b0;
    push_byte(8'h9a);
    av_wr(3'd0, 32'h5000); av_wr(3'd1, 32'd1);
    mon_clear();
    start_xfer();
    av_wr(3'd0, 32'h6000);
    av_wr(3'd3, 32'h1);
    mem_gnt = 1'b1;
    wait_idle(1'b0);
    void'(mfifo.pop_front());
    chk("busy_start_n", 32'(mon_addr.size()), 32'd1);
    if (mon_addr.size() > 0) chk("busy_start_addr", 32'(mon_addr[0]), 32'h5000);
    av_rd(3'd4, rd); chk("busy_start_cur", rd, 32'h5001);

    // Abort during STROBE
    push_byte(8'ha1); push_byte(8'ha2); push_byte(8'ha3);
    av_wr(3'd0, 32'h2000); av_wr(3'd1, 32'd3);
    mon_clear();
    start_xfer();
    wait_we_low("abort_we_seen");
    av_wr(3'd3, 32'h2);
    wait_idle(1'b0);
    mfifo.delete();
    chk("abort_writes", 32'(mon_addr.size()), 32'd1);
    if (mon_width.size() > 0) chk("abort_width", 32'(mon_width[0]), 32'(W));
    av_rd(3'd3, rd);
    chk("abort_done", 32'(rd[2]), 32'd0);
    chk("abort_level", 32'(rd[12:8]), 32'd0);
    chk("abort_req", 32'(mem_req), 32'd0);

    // Asynchronous reset mid-strobe
    push_byte(8'h42); push_byte(8'h43);
    av_wr(3'd0, 32'h7777); av_wr(3'd1, 32'd2);
    start_xfer();
    wait_we_low("rst_we_seen");
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_we", 32'(mem_we_n), 32'd1);
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_addr", {16'h0, mem_addr}, 32'd0);
    av_rd(3'd3, rd); chk("arst_status", rd, 32'd0);
    av_rd(3'd0, rd); chk("arst_base", rd, 32'd0);
    reset_n = 1'b1;
    mfifo.delete();
    movf = 1'b0;
    @(posedge clk); #1;
    mon_clear();

`ifdef SD_LOADER_VERIFY_EN
    // Read-back mismatch stops the transfer
    push_byte(8'ha5); push_byte(8'ha6);
    rd_corrupt = 8'h01;
    av_wr(3'd0, 32'h3000); av_wr(3'd1, 32'd2);
    mon_clear();
    start_xfer();
    wait_idle(1'b0);
    rd_corrupt = 8'h00;
    chk("verr_writes", 32'(mon_addr.size()), 32'd1);
    av_rd(3'd3, rd);
    chk("verr_flag", 32'(rd[4]), 32'd1);
    chk("verr_done", 32'(rd[2]), 32'd0);
    av_wr(3'd3, 32'h2);
    mfifo.delete();
    av_rd(3'd3, rd);
    chk("verr_flush", 32'(rd[12:8]), 32'd0);
`endif

    // Randomized transfers with a toggling grant
    for (int it = 0; it < 25; it++) begin
      mem_gnt = 1'b1;
      np = $urandom_range(0, 5);
      for (int i = 0; i < np; i++) push_byte(8'($urandom));
      av_rd(3'd3, rd);
      chk("rnd_ovf", 32'(rd[3]), 32'(movf));
      chk("rnd_lvl", 32'(rd[12:8]), 32'(mfifo.size()));
      cnt  = 16'($urandom_range(0, mfifo.size()));
      base = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hfffc, 16'hffff)) : 16'($urandom);
      run_xfer(base, cnt, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
